// File: rtl/cpu_mem_access_ctrl_pkg.sv
// Shared types and helpers for the CPU memory access controller.
package cpu_mem_access_ctrl_pkg;

    localparam int unsigned CPU_ADDR_W = 32;

    typedef enum logic [1:0] {
        ReqDataSz8  = 2'd0,
        ReqDataSz16 = 2'd1,
        ReqDataSz32 = 2'd2,
        ReqDataSz48 = 2'd3
    } ReqDataSz;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } MemCtrlState;

    typedef enum logic {
        DirRead  = 1'b0,
        DirWrite = 1'b1
    } MemDir;

    typedef struct packed {
        logic [CPU_ADDR_W-1:0] addr;
        ReqDataSz              size;
        MemDir                 dir;
        logic [31:0]           wdata;
    } StrcMemCtrlReq;

    // 48-bit accesses only exist for fetch; a 48-bit write collapses to 32 bits.
    function automatic logic [2:0] req_size_to_nbytes(input ReqDataSz size, input MemDir dir);
        logic [2:0] n;
        case (size)
            ReqDataSz8:  n = 3'd1;
            ReqDataSz16: n = 3'd2;
            ReqDataSz32: n = 3'd4;
            default:     n = (dir == DirWrite) ? 3'd4 : 3'd6;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] beat_count(input logic addr_lsb, input logic [2:0] nbytes);
        logic [3:0] sum;
        sum = {3'b000, addr_lsb} + {1'b0, nbytes} + 4'd1;
        return sum[3:1];
    endfunction

endpackage

// File: rtl/cpu_mem_access_ctrl_lane_calc.sv
// Per-beat halfword address, byte lanes, lane-aligned write data and read byte offset.
module cpu_mem_lane_calc
    import cpu_mem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        nbytes_i,
    input  logic [1:0]        beat_idx_i,
    input  logic [31:0]       wdata_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [1:0]        byte_en_o,
    output logic [15:0]       wr_data_o,
    output logic [2:0]        rd_off_o
);

    logic [2:0] beats;

    assign beats      = beat_count(addr_i[0], nbytes_i);
    assign mem_addr_o = {addr_i[ADDR_W-1:1], 1'b0} + ADDR_W'({beat_idx_i, 1'b0});
    // Offset of the low lane relative to the request address; wraps to 7 (-1) on an odd first beat.
    assign rd_off_o   = {beat_idx_i, 1'b0} - {2'b00, addr_i[0]};

    always_comb begin
        byte_en_o = 2'b11;
        if ((beat_idx_i == 2'd0) && addr_i[0]) begin
            byte_en_o[0] = 1'b0;
        end
        if (({1'b0, beat_idx_i} == beats - 3'd1) && (addr_i[0] ^ nbytes_i[0])) begin
            byte_en_o[1] = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [2:0] off;
            assign off = rd_off_o + 3'(gi);
            assign wr_data_o[gi*8 +: 8] = (byte_en_o[gi] && !off[2])
                                        ? wdata_i[{off[1:0], 3'b000} +: 8] : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/cpu_mem_access_ctrl.sv
// Splits CPU memory requests into 16-bit bus beats and assembles read data.
// Optional per-beat ack timeout enabled by defining CPU_MEM_TIMEOUT_EN.
module cpu_mem_access_ctrl
    import cpu_mem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W         = CPU_ADDR_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_rd,
    input  logic              cpu_req_wr,
    input  logic [1:0]        cpu_req_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wr_data,
    output logic              cpu_enable,
    output logic [47:0]       cpu_data_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_byte_en,
    output logic [15:0]       mem_wr_data,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rd_data,
    output logic              bus_err
);

    MemCtrlState        state_q, state_d;
    StrcMemCtrlReq      req_q, req_d;
    logic [1:0]         idx_q, idx_d;
    logic [5:0][7:0]    data_q, data_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [1:0]         mem_byte_en_q;
    logic [15:0]        mem_wr_data_q;
    logic [2:0]         rd_off_q;
    logic               load_beat;
    logic               last_beat;
    logic               timeout_hit;
    logic [2:0]         beats_q;

    logic [ADDR_W-1:0]  lc_mem_addr;
    logic [1:0]         lc_byte_en;
    logic [15:0]        lc_wr_data;
    logic [2:0]         lc_rd_off;

    // Lane calculator looks at the beat about to be issued, so outputs can be registered.
    cpu_mem_lane_calc #(.ADDR_W(ADDR_W)) u_lane_calc (
        .addr_i     (ADDR_W'(req_d.addr)),
        .nbytes_i   (req_size_to_nbytes(req_d.size, req_d.dir)),
        .beat_idx_i (idx_d),
        .wdata_i    (req_d.wdata),
        .mem_addr_o (lc_mem_addr),
        .byte_en_o  (lc_byte_en),
        .wr_data_o  (lc_wr_data),
        .rd_off_o   (lc_rd_off)
    );

    assign beats_q   = beat_count(req_q.addr[0], req_size_to_nbytes(req_q.size, req_q.dir));
    assign last_beat = ({1'b0, idx_q} == beats_q - 3'd1);

`ifdef CPU_MEM_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             bus_err_q;

    assign timeout_hit = (state_q == ISSUE) && !mem_ack && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = '0;
        if ((state_q == ISSUE) && !mem_ack && !timeout_hit) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            bus_err_q <= timeout_hit;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        idx_d     = idx_q;
        mem_req_d = 1'b0;
        load_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req_rd || cpu_req_wr) begin
                    req_d.addr  = CPU_ADDR_W'(cpu_addr);
                    req_d.size  = ReqDataSz'(cpu_req_size);
                    req_d.dir   = cpu_req_rd ? DirRead : DirWrite;
                    req_d.wdata = cpu_wr_data;
                    idx_d       = 2'd0;
                    load_beat   = 1'b1;
                    mem_req_d   = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_d = 1'b1;
                if (mem_ack) begin
                    if (last_beat) begin
                        mem_req_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        load_beat = 1'b1;
                    end
                end else if (timeout_hit) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        logic [2:0] off;
        data_d = data_q;
        off    = 3'd0;
        if ((state_q == IDLE) && (cpu_req_rd || cpu_req_wr)) begin
            data_d = '0;
        end else if ((state_q == ISSUE) && mem_ack) begin
            for (int l = 0; l < 2; l++) begin
                off = rd_off_q + 3'(l);
                if (mem_byte_en_q[l] && (off < 3'd6)) begin
                    data_d[off] = mem_rd_data[l*8 +: 8];
                end
            end
        end else if (timeout_hit) begin
            data_d = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            req_q         <= '0;
            idx_q         <= 2'd0;
            data_q        <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_byte_en_q <= 2'b00;
            mem_wr_data_q <= 16'h0000;
            rd_off_q      <= 3'd0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            mem_req_q <= mem_req_d;
            if (load_beat) begin
                mem_we_q      <= (req_d.dir == DirWrite);
                mem_addr_q    <= lc_mem_addr;
                mem_byte_en_q <= lc_byte_en;
                mem_wr_data_q <= lc_wr_data;
                rd_off_q      <= lc_rd_off;
            end
        end
    end

    assign cpu_enable  = ((state_q == IDLE) && !cpu_req_rd && !cpu_req_wr) || (state_q == DONE);
    assign cpu_data_in = data_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_byte_en = mem_byte_en_q;
    assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_cpu_mem_access_ctrl.sv
// Directed self-checking bench for cpu_mem_access_ctrl.
module tb_cpu_mem_access_ctrl;

`ifdef CPU_MEM_TIMEOUT_EN
    localparam int unsigned TB_TMO = 4;
`else
    localparam int unsigned TB_TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_rd = 1'b0;
    logic        cpu_req_wr = 1'b0;
    logic [1:0]  cpu_req_size = 2'd0;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wr_data = 32'h0;
    logic        cpu_enable;
    logic [47:0] cpu_data_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_byte_en;
    logic [15:0] mem_wr_data;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rd_data;
    logic        bus_err;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_delay = 0;
    int ack_cnt = 0;

    logic [31:0] b_addr [8];
    logic [1:0]  b_be   [8];
    logic [15:0] b_wd   [8];
    logic        b_we   [8];
    int          nb;
    int          low;
    logic [47:0] rdata;

    cpu_mem_access_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req_rd   (cpu_req_rd),
        .cpu_req_wr   (cpu_req_wr),
        .cpu_req_size (cpu_req_size),
        .cpu_addr     (cpu_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_enable   (cpu_enable),
        .cpu_data_in  (cpu_data_in),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_byte_en  (mem_byte_en),
        .mem_wr_data  (mem_wr_data),
        .mem_ack      (mem_ack),
        .mem_rd_data  (mem_rd_data),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    // Memory image: byte at address A reads as A[7:0], except two hand-picked words.
    always_comb begin
        case (mem_addr)
            32'h0000_0100: mem_rd_data = 16'h2211;
            32'h0000_0102: mem_rd_data = 16'h4433;
            default:       mem_rd_data = {mem_addr[7:0] + 8'd1, mem_addr[7:0]};
        endcase
    end

    always @(negedge clk) begin
        if (mem_req && (ack_cnt >= ack_delay)) begin
            mem_ack = 1'b1;
            ack_cnt = 0;
        end else begin
            mem_ack = 1'b0;
            if (mem_req) ack_cnt++;
            else         ack_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic run_access(input logic rd, input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
        bit fin;
        fin = 1'b0;
        nb  = 0;
        low = 0;
        @(negedge clk);
        cpu_req_rd   = rd;
        cpu_req_wr   = wr;
        cpu_req_size = size;
        cpu_addr     = addr;
        cpu_wr_data  = wdata;
        for (int c = 0; c < 200 && !fin; c++) begin
            #1;
            if (mem_req && mem_ack && nb < 8) begin
                b_addr[nb] = mem_addr;
                b_be[nb]   = mem_byte_en;
                b_wd[nb]   = mem_wr_data;
                b_we[nb]   = mem_we;
                nb++;
            end
            if (!cpu_enable) begin
                low++;
            end else begin
                rdata      = cpu_data_in;
                fin        = 1'b1;
                cpu_req_rd = 1'b0;
                cpu_req_wr = 1'b0;
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) check("access_done_in_budget", 64'd0, 64'd1);
        @(negedge clk);
        $display("access rd=%0b wr=%0b size=%0d addr=0x%08h beats=%0d low=%0d data=0x%012h",
                 rd, wr, size, addr, nb, low, rdata);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got 0x0 expected 0x1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_cpu_enable", 64'(cpu_enable), 64'd1);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_byte_en", 64'(mem_byte_en), 64'd0);
        check("rst_wr_data", 64'(mem_wr_data), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_data_in", 64'(cpu_data_in), 64'd0);
        check("rst_bus_err", 64'(bus_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Aligned 32-bit read
        run_access(1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
        check("r32_beats", 64'(nb), 64'd2);
        check("r32_addr0", 64'(b_addr[0]), 64'h100);
        check("r32_addr1", 64'(b_addr[1]), 64'h102);
        check("r32_be0", 64'(b_be[0]), 64'd3);
        check("r32_be1", 64'(b_be[1]), 64'd3);
        check("r32_data", 64'(rdata), 64'h0000_4433_2211);
        check("r32_low", 64'(low), 64'd3);
        #1;
        check("idle_req_low", 64'(mem_req), 64'd0);
        check("idle_addr_hold", 64'(mem_addr), 64'h102);

        // Odd 48-bit fetch
        run_access(1'b1, 1'b0, 2'd3, 32'h0000_0201, 32'h0);
        check("r48_beats", 64'(nb), 64'd4);
        check("r48_addr0", 64'(b_addr[0]), 64'h200);
        check("r48_addr3", 64'(b_addr[3]), 64'h206);
        check("r48_be0", 64'(b_be[0]), 64'd2);
        check("r48_be1", 64'(b_be[1]), 64'd3);
        check("r48_be2", 64'(b_be[2]), 64'd3);
        check("r48_be3", 64'(b_be[3]), 64'd1);
        check("r48_data", 64'(rdata), 64'h0605_0403_0201);
        check("r48_low", 64'(low), 64'd5);

        // Odd byte write
        run_access(1'b0, 1'b1, 2'd0, 32'h0000_0033, 32'h0000_00AB);
        check("w8_beats", 64'(nb), 64'd1);
        check("w8_addr", 64'(b_addr[0]), 64'h32);
        check("w8_be", 64'(b_be[0]), 64'd2);
        check("w8_wd_hi", 64'(b_wd[0][15:8]), 64'hAB);
        check("w8_we", 64'(b_we[0]), 64'd1);
        check("w8_low", 64'(low), 64'd2);

        // Size-3 write at odd address behaves as a 32-bit write
        run_access(1'b0, 1'b1, 2'd3, 32'h0000_0101, 32'h4433_2211);
        check("w48_beats", 64'(nb), 64'd3);
        check("w48_be0", 64'(b_be[0]), 64'd2);
        check("w48_be2", 64'(b_be[2]), 64'd1);
        check("w48_wd0_hi", 64'(b_wd[0][15:8]), 64'h11);
        check("w48_wd1", 64'(b_wd[1]), 64'h3322);
        check("w48_wd2_lo", 64'(b_wd[2][7:0]), 64'h44);
        check("w48_addr2", 64'(b_addr[2]), 64'h104);

        // Address wrap at the top of the space
        run_access(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0);
        check("wrap_addr0", 64'(b_addr[0]), 64'hFFFF_FFFE);
        check("wrap_addr1", 64'(b_addr[1]), 64'h0);
        check("wrap_data", 64'(rdata), 64'h0000_0100_FFFE);

        // Odd 16-bit read spans two halfwords
        run_access(1'b1, 1'b0, 2'd1, 32'h0000_0105, 32'h0);
        check("r16o_beats", 64'(nb), 64'd2);
        check("r16o_be0", 64'(b_be[0]), 64'd2);
        check("r16o_be1", 64'(b_be[1]), 64'd1);
        check("r16o_data", 64'(rdata), 64'h0605);

        // Read wins when both requests are set; even byte uses low lane
        run_access(1'b1, 1'b1, 2'd0, 32'h0000_0040, 32'hFFFF_FFFF);
        check("prio_we", 64'(b_we[0]), 64'd0);
        check("prio_be", 64'(b_be[0]), 64'd1);
        check("prio_data", 64'(rdata), 64'h40);

        // Wait states stretch the stall
        ack_delay = 2;
        run_access(1'b1, 1'b0, 2'd1, 32'h0000_0010, 32'h0);
        check("ws_data", 64'(rdata), 64'h1110);
        check("ws_low", 64'(low), 64'd4);

        // Reset in the third wait cycle of a beat
        ack_delay = 5;
        @(negedge clk);
        cpu_req_rd   = 1'b1;
        cpu_req_size = 2'd2;
        cpu_addr     = 32'h0000_0100;
        for (int c = 0; c < 20 && !mem_req; c++) @(negedge clk);
        check("rstmid_issue", 64'(mem_req), 64'd1);
        cpu_req_rd = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_req", 64'(mem_req), 64'd0);
        check("rstmid_enable", 64'(cpu_enable), 64'd1);
        check("rstmid_data", 64'(cpu_data_in), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        ack_delay = 0;
        @(negedge clk);
        #1;
        check("rstmid_stays_idle", 64'(mem_req), 64'd0);

`ifdef CPU_MEM_TIMEOUT_EN
        ack_delay = 1000;
        @(negedge clk);
        cpu_req_rd   = 1'b1;
        cpu_req_size = 2'd2;
        cpu_addr     = 32'h0000_0100;
        for (int c = 0; c < 50 && !bus_err; c++) begin
            @(negedge clk);
            #1;
        end
        check("tmo_bus_err", 64'(bus_err), 64'd1);
        check("tmo_data", 64'(cpu_data_in), 64'hFFFF_FFFF_FFFF);
        check("tmo_enable", 64'(cpu_enable), 64'd1);
        cpu_req_rd = 1'b0;
        @(negedge clk);
        #1;
        check("tmo_pulse_end", 64'(bus_err), 64'd0);
        check("tmo_idle", 64'(cpu_enable), 64'd1);
        ack_delay = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_mem_access_ctrl.md
Name: cpu_mem_access_ctrl

Overview:
- Sits directly upstream of the Cpu core.
- Takes the Cpu's level-style memory request (address, size, read/write, write data) and performs it as one or more 16-bit beats on the external memory bus.
- Stalls the core via cpu_enable while busy, and returns little-endian assembled read data on cpu_data_in, up to 48 bits for instruction fetch.

Parameters:
- ADDR_W, 32, byte address width; address arithmetic wraps modulo 2^ADDR_W.
- TIMEOUT_CYCLES, 255, per-beat ack wait limit; used only with CPU_MEM_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req_rd  in  1  read request, level.
- cpu_req_wr  in  1  write request, level; cpu_req_rd has priority if both are set.
- cpu_req_size  in  2  0=8b, 1=16b, 2=32b, 3=48b (48b is read only; a write of size 3 is treated as 32b).
- cpu_addr  in  ADDR_W  byte address; any alignment is allowed.
- cpu_wr_data  in  32  write data; byte k goes to cpu_addr+k.
- cpu_enable  out  1  drives Cpu.enable.
- cpu_data_in  out  48  drives Cpu.data_in.
- mem_req  out  1  beat request.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  halfword address, bit0 always 0.
- mem_byte_en  out  2  bit0 = low byte lane (even address), bit1 = high lane.
- mem_wr_data  out  16  lane-aligned write data.
- mem_ack  in  1  beat completes on any posedge where mem_req && mem_ack.
- mem_rd_data  in  16  sampled on the completing edge.
- bus_err  out  1  one-cycle timeout pulse; constant 0 without the optional feature.

Behaviour:
- Reset values: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_byte_en=0, mem_wr_data=0, cpu_data_in=0, bus_err=0, beat counter=0. cpu_enable=1, since it is combinational from IDLE with no request.
- States: IDLE, ISSUE, DONE.
- cpu_enable (combinational) = (IDLE && !cpu_req_rd && !cpu_req_wr) || DONE.
- IDLE:
  - Request present at the edge: latch addr/size/dir/wdata, clear cpu_data_in, compute the beat count, go to ISSUE.
  - Beat count = (addr[0] + nbytes + 1) >> 1, where nbytes = 1/2/4/6. Range is 1..4.
- ISSUE:
  - mem_req=1.
  - Beat i: mem_addr = {addr[ADDR_W-1:1],0} + 2i, with wrap (0xFFFFFFFE+2 -> 0x0).
  - mem_byte_en: first beat with odd addr = 2'b10. Last beat with (addr[0]+nbytes) odd = 2'b01. Otherwise 2'b11. A 1-beat odd byte access = 2'b10.
  - Each completing edge: store read lanes into cpu_data_in at byte offset (beat byte address − cpu_addr), and increment i.
  - Last beat completing: go to DONE and drop mem_req in the same edge.
- DONE:
  - Exactly one cycle; cpu_data_in holds the result, with unused upper bytes 0.
  - Next edge returns to IDLE.
- Latency: with zero-wait-state memory, cpu_enable is low for beats+1 cycles. An aligned 32b read holds it low 3 cycles.
- Upstream rule: the core must replace or deassert its request on the enabled DONE edge; a request still present in IDLE is a new access.
- Requests changing while in ISSUE are ignored, since the latched copy is used.
- Reset mid-access: immediate return to IDLE with mem_req=0. The in-flight beat is abandoned and no data is returned.
- No request and no memory activity: all mem_* outputs hold their previous values except mem_req=0.

Optional Feature:
- CPU_MEM_TIMEOUT_EN defined:
  - A per-beat counter starts at 0 when the beat is issued.
  - If it reaches TIMEOUT_CYCLES without ack: mem_req drops, cpu_data_in is set to all-ones, bus_err pulses for the DONE cycle, state goes to DONE, and remaining beats are skipped.
- Undefined: no counter; ISSUE waits indefinitely; bus_err is tied 0.

Decomposition:
- pkg_cpu gains:
  - enum ReqDataSz (ReqDataSz8/16/32/48, 2 bits).
  - enum MemCtrlState.
  - packed struct StrcMemCtrlReq (addr, size, dir, wdata).
  - function req_size_to_nbytes.
- Sub-module cpu_mem_lane_calc (combinational): from latched addr, nbytes and beat index, produce mem_addr, mem_byte_en, mem_wr_data, and the read byte offset.
- The FSM, counters and assembly stay in cpu_mem_access_ctrl.

Test Plan:
- Read size 2, addr 0x100, ack always 1, mem data 0x2211 then 0x4433 -> 2 beats at 0x100/0x102 with byte_en 11/11; cpu_data_in=0x000044332211; cpu_enable low 3 cycles.
- Read size 3, addr 0x201 -> 4 beats at 0x200..0x206 with byte_en 10,11,11,01; the 6 bytes are packed from 0x201 upward.
- Write size 0, addr 0x33, wdata 0xAB -> 1 beat at 0x32, byte_en 10, mem_wr_data[15:8]=0xAB, mem_we=1.
- Read size 2, addr 0xFFFFFFFE -> beats at 0xFFFFFFFE then 0x00000000.
- Ack delayed 5 cycles per beat, rst asserted in the 3rd wait cycle -> mem_req=0 immediately, IDLE, cpu_enable=1, cpu_data_in=0.
- With CPU_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> bus_err 1 for one cycle, cpu_data_in=all-ones, then IDLE.
